// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver
// Producer end of a J/K interface. Takes word-level commands (load, clear,
// set, invert, count up/down), turns each one into per-bit J/K excitation
// derived from the bank's fed-back Q, drives it for one cycle, and then
// verifies that the external JK bank settled on the expected word.
module jk_excitation_driver #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PREP  = 2'd1;
  localparam logic [1:0] DRIVE = 2'd2;
  localparam logic [1:0] CHECK = 2'd3;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_CLEAR  = 3'd2;
  localparam logic [2:0] OP_SET    = 3'd3;
  localparam logic [2:0] OP_INVERT = 3'd4;
  localparam logic [2:0] OP_UP     = 3'd5;
  localparam logic [2:0] OP_DOWN   = 3'd6;
  localparam logic [2:0] OP_RSVD   = 3'd7;

  logic [1:0]       r_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_steps;
  logic [WIDTH-1:0] r_expected;
  logic [WIDTH-1:0] r_j;
  logic [WIDTH-1:0] r_k;
  logic             r_done;
  logic             r_err;

  logic [WIDTH-1:0] w_upMask;
  logic [WIDTH-1:0] w_downMask;
  logic             w_upRun;
  logic             w_downRun;
  logic [WIDTH-1:0] w_expNext;
  logic [WIDTH-1:0] w_jNext;
  logic [WIDTH-1:0] w_kNext;
  logic [CNT_W-1:0] w_cmdSteps;

  assign w_cmdSteps = cmd_data[CNT_W-1:0];

  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign err       = r_err;
  assign j_out     = r_j;
  assign k_out     = r_k;

  // Ripple toggle masks: a bit flips on increment when all lower bits are 1, on decrement when all lower bits are 0
  always_comb begin
    w_upMask   = '0;
    w_downMask = '0;
    w_upRun    = 1'b1;
    w_downRun  = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      w_upMask[i]   = w_upRun;
      w_downMask[i] = w_downRun;
      w_upRun       = w_upRun & q_fb[i];
      w_downRun     = w_downRun & ~q_fb[i];
    end
  end

  // Expected landing value and J/K excitation for the current op, computed from the Q snapshot seen in PREP
  always_comb begin
    w_expNext = '0;
    w_jNext   = '0;
    w_kNext   = '0;
    case (r_op)
      OP_LOAD: begin
        w_expNext = r_data;
        w_jNext   = r_data & ~q_fb;
        w_kNext   = ~r_data & q_fb;
      end
      OP_CLEAR: begin
        w_expNext = '0;
        w_kNext   = '1;
      end
      OP_SET: begin
        w_expNext = '1;
        w_jNext   = '1;
      end
      OP_INVERT: begin
        w_expNext = ~q_fb;
        w_jNext   = '1;
        w_kNext   = '1;
      end
      OP_UP: begin
        w_expNext = q_fb + WIDTH'(1);
        w_jNext   = w_upMask;
        w_kNext   = w_upMask;
      end
      OP_DOWN: begin
        w_expNext = q_fb - WIDTH'(1);
        w_jNext   = w_downMask;
        w_kNext   = w_downMask;
      end
      default: begin
        w_expNext = '0;
        w_jNext   = '0;
        w_kNext   = '0;
      end
    endcase
  end

  // Command sequencer: accept in IDLE, then PREP -> DRIVE -> CHECK per step; J/K are only nonzero during DRIVE
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state    <= IDLE;
      r_op       <= '0;
      r_data     <= '0;
      r_steps    <= '0;
      r_expected <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_j    <= '0;
      r_k    <= '0;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_op   <= cmd_op;
            r_data <= cmd_data;
            r_err  <= 1'b0;
            case (cmd_op)
              OP_NOP: begin
                r_done <= 1'b1;
              end
              OP_RSVD: begin
                r_err  <= 1'b1;
                r_done <= 1'b1;
              end
              OP_UP, OP_DOWN: begin
                if (w_cmdSteps == '0) begin
                  r_done <= 1'b1;
                end else begin
                  r_steps <= w_cmdSteps;
                  r_state <= PREP;
                end
              end
              default: begin
                r_steps <= CNT_W'(1);
                r_state <= PREP;
              end
            endcase
          end
        end
        PREP: begin
          r_expected <= w_expNext;
          r_j        <= w_jNext;
          r_k        <= w_kNext;
          r_state    <= DRIVE;
        end
        DRIVE: begin
          r_state <= CHECK;
        end
        CHECK: begin
          if (q_fb != r_expected) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else if (r_steps > CNT_W'(1)) begin
            r_steps <= r_steps - CNT_W'(1);
            r_state <= PREP;
          end else begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// tb_jk_excitation_driver
// Drives directed commands into jk_excitation_driver against a behavioural
// JK bank. Expected drive cycles and completions go into scoreboard queues;
// a negedge monitor pops and compares them whenever the DUT drives J/K or
// pulses done.
module tb_jk_excitation_driver;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             Clk = 1'b0;
  logic             Reset_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j_out;
  logic [WIDTH-1:0] k_out;
  logic             busy;
  logic             done;
  logic             err;

  logic [WIDTH-1:0] bankQ = '0;
  logic [WIDTH-1:0] stuckMask = '0;
  logic [WIDTH-1:0] presetVal = '0;
  logic             presetEn = 1'b0;
  int               cycle = 0;

  int total = 0;
  int failed = 0;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
  } driveExp_t;

  typedef struct {
    string            name;
    logic             errV;
    logic [WIDTH-1:0] q;
    int               lat;
    int               acceptCycle;
  } doneExp_t;

  driveExp_t driveQ[$];
  doneExp_t  doneQ[$];

  jk_excitation_driver #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .q_fb      (q_fb),
    .j_out     (j_out),
    .k_out     (k_out),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 Clk = ~Clk;

  // Edge counter used to measure latency from the accepting edge to done
  always @(posedge Clk) cycle <= cycle + 1;

  // Behavioural JK bank; stuckMask forces the selected bits to read and store 0
  assign q_fb = bankQ & ~stuckMask;

  always @(posedge Clk) begin
    if (presetEn) bankQ <= presetVal;
    else          bankQ <= ((j_out & ~q_fb) | (~k_out & q_fb)) & ~stuckMask;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushDrive(input string name, input logic [WIDTH-1:0] j, input logic [WIDTH-1:0] k);
    driveExp_t d;
    d.name = name;
    d.j    = j;
    d.k    = k;
    driveQ.push_back(d);
  endtask

  // Monitor: every nonzero J/K cycle must match the next expected drive, every done the next completion
  always @(negedge Clk) begin : monitor
    driveExp_t d;
    doneExp_t  e;
    if ((j_out | k_out) != '0) begin
      if (driveQ.size() == 0) begin
        total++;
        failed++;
        $display("[TB] FAIL unexpected_drive: actual j=0x%0h k=0x%0h required none", j_out, k_out);
      end else begin
        d = driveQ.pop_front();
        checkOutput({d.name, " j_out"}, 32'(j_out), 32'(d.j));
        checkOutput({d.name, " k_out"}, 32'(k_out), 32'(d.k));
      end
    end
    if (done === 1'b1) begin
      if (doneQ.size() == 0) begin
        total++;
        failed++;
        $display("[TB] FAIL unexpected_done: actual done=1 err=%0b required no completion", err);
      end else begin
        e = doneQ.pop_front();
        checkOutput({e.name, " err"}, 32'(err), 32'(e.errV));
        checkOutput({e.name, " q_fb"}, 32'(q_fb), 32'(e.q));
        checkOutput({e.name, " latency"}, 32'(cycle - e.acceptCycle), 32'(e.lat));
      end
    end
  end

  task automatic setBank(input logic [WIDTH-1:0] val);
    @(negedge Clk);
    presetVal = val;
    presetEn  = 1'b1;
    @(posedge Clk);
    #1 presetEn = 1'b0;
  endtask

  // Issue one command; latency is counted in edges after the accepting edge
  task automatic applyStimulus(input string name, input logic [2:0] op, input logic [WIDTH-1:0] data,
                               input logic expErr, input logic [WIDTH-1:0] expQ, input int expLat,
                               input bit holdBusy, input bit checkErrClear);
    int guard;
    doneExp_t e;
    guard = 0;
    @(negedge Clk);
    while (cmd_ready !== 1'b1 && guard < 50) begin
      @(negedge Clk);
      guard++;
    end
    if (guard >= 50) begin
      total++;
      failed++;
      $display("[TB] FAIL %s ready_timeout: actual cmd_ready=%0b required 1", name, cmd_ready);
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(posedge Clk);
    #1;
    e.name        = name;
    e.errV        = expErr;
    e.q           = expQ;
    e.lat         = expLat;
    e.acceptCycle = cycle;
    doneQ.push_back(e);
    if (checkErrClear) checkOutput({name, " err_cleared_on_accept"}, 32'(err), 32'(0));
    if (holdBusy) begin
      cmd_op   = 3'd7;
      cmd_data = '0;
      @(posedge Clk);
      @(posedge Clk);
      #1;
    end
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = '0;
  endtask

  task automatic waitIdle(input string name);
    int guard;
    guard = 0;
    do begin
      @(negedge Clk);
      #1;
      guard++;
    end while ((doneQ.size() != 0 || driveQ.size() != 0) && guard < 100);
    if (guard >= 100) begin
      total++;
      failed++;
      $display("[TB] FAIL %s done_timeout: actual pending=%0d required 0", name, doneQ.size() + driveQ.size());
      doneQ.delete();
      driveQ.delete();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: actual still running required finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    Reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = '0;
    presetVal = '0;
    presetEn  = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    checkOutput("reset j_out", 32'(j_out), 32'(0));
    checkOutput("reset k_out", 32'(k_out), 32'(0));
    checkOutput("reset done", 32'(done), 32'(0));
    checkOutput("reset err", 32'(err), 32'(0));
    checkOutput("reset busy", 32'(busy), 32'(0));
    checkOutput("reset cmd_ready", 32'(cmd_ready), 32'(1));
    presetEn = 1'b0;
    Reset_n  = 1'b1;

    // LOAD 0xA5 over 0x3C: set bits 7,0; clear bits 4,3
    setBank(8'h3C);
    pushDrive("load_a5", 8'h81, 8'h18);
    applyStimulus("load_a5", 3'd1, 8'hA5, 1'b0, 8'hA5, 3, 1'b0, 1'b0);
    waitIdle("load_a5");

    // COUNT_UP x3 from 0xFD: FE (mask 03), FF (mask 01), 00 (mask FF); busy-time cmd_valid held
    setBank(8'hFD);
    pushDrive("up3_s1", 8'h03, 8'h03);
    pushDrive("up3_s2", 8'h01, 8'h01);
    pushDrive("up3_s3", 8'hFF, 8'hFF);
    applyStimulus("count_up3", 3'd5, 8'h03, 1'b0, 8'h00, 9, 1'b1, 1'b0);
    waitIdle("count_up3");

    // COUNT_DOWN x2 from 0x01: 00 (mask 01), FF (mask FF)
    setBank(8'h01);
    pushDrive("dn2_s1", 8'h01, 8'h01);
    pushDrive("dn2_s2", 8'hFF, 8'hFF);
    applyStimulus("count_down2", 3'd6, 8'h02, 1'b0, 8'hFF, 6, 1'b0, 1'b0);
    waitIdle("count_down2");

    // SET with bit 3 stuck low lands on 0xF7 and flags err
    @(negedge Clk);
    stuckMask = 8'h08;
    pushDrive("set_stuck", 8'hFF, 8'h00);
    applyStimulus("set_stuck", 3'd3, 8'h00, 1'b1, 8'hF7, 3, 1'b0, 1'b0);
    waitIdle("set_stuck");
    @(negedge Clk);
    stuckMask = 8'h00;

    // LOAD 0x00 from 0xF7 clears err on accept
    pushDrive("load_00", 8'h00, 8'hF7);
    applyStimulus("load_00", 3'd1, 8'h00, 1'b0, 8'h00, 3, 1'b0, 1'b1);
    waitIdle("load_00");

    // Reserved op, zero-step count (upper data bits ignored), and NOP: no drive at all
    applyStimulus("op7", 3'd7, 8'h00, 1'b1, 8'h00, 0, 1'b0, 1'b0);
    waitIdle("op7");
    applyStimulus("count_zero", 3'd5, 8'h10, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    waitIdle("count_zero");
    applyStimulus("nop", 3'd0, 8'h5A, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    waitIdle("nop");

    // Reset during the INVERT drive cycle aborts the command
    setBank(8'h5A);
    pushDrive("invert_abort", 8'hFF, 8'hFF);
    @(negedge Clk);
    cmd_valid = 1'b1;
    cmd_op    = 3'd4;
    cmd_data  = '0;
    @(posedge Clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b0;
    @(posedge Clk);
    #1;
    checkOutput("abort j_out", 32'(j_out), 32'(0));
    checkOutput("abort k_out", 32'(k_out), 32'(0));
    checkOutput("abort busy", 32'(busy), 32'(0));
    checkOutput("abort cmd_ready", 32'(cmd_ready), 32'(1));
    checkOutput("abort done", 32'(done), 32'(0));
    Reset_n = 1'b1;

    // Bank took the inversion at the reset edge; driver must be usable again
    applyStimulus("nop_after_abort", 3'd0, 8'h00, 1'b0, 8'hA5, 0, 1'b0, 1'b0);
    waitIdle("nop_after_abort");

    repeat (3) @(negedge Clk);
    checkOutput("drive queue drained", 32'(driveQ.size()), 32'(0));
    checkOutput("done queue drained", 32'(doneQ.size()), 32'(0));

    $display("%0d/%0d checks passed", total - failed, total);
    $finish;
  end

endmodule
